muldiv_ctrl: RTL

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair behind the ALU front end. It accepts MIPS SPECIAL-class func codes (mult, multu, div, divu, mthi, mtlo) from the decode stage. It iterates one bit per cycle and raises busy so the pipeline holds any later HI/LO consumer until the result commits.

---
 rtl/muldiv_ctrl_pkg.sv | 21 ++
 rtl/muldiv_ctrl_if.sv | 20 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: MIPS SPECIAL
// func codes and the sequencer state encoding.
package muldiv_ctrl_pkg;

   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1a;
   localparam logic [5:0] FUNC_DIVU  = 6'h1b;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode-side request bus and HI/LO result bus of the multiply/divide sequencer.
interface muldiv_ctrl_if #(parameter int XLEN = 32);

   logic            start;
   logic [5:0]      func;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (output start, func, op1, op2, flush,
                   input  busy, done, hi, lo);

   modport slave  (input  start, func, op1, op2, flush,
                   output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on the {upper, lower} accumulator.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   input  logic              is_div_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shl;
   logic [XLEN:0] diff;

   always_comb begin
      sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      shl  = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      diff = shl - {1'b0, opnd_i};
      // Divide: a borrow out of diff means the divisor did not fit; keep shl.
      if (is_div_i) begin
         if (diff[XLEN]) acc_o = {shl[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         else            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning HI/LO: IDLE -> PREP -> RUN (ITER steps)
// -> FIX, with mthi/mtlo written directly from IDLE.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ITER = XLEN
) (
   input  logic        clk,
   input  logic        rst,
   muldiv_ctrl_if.slave bus
);

   localparam int CW = $clog2(ITER);
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_PREP = ST_PREP;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_FIX  = ST_FIX;

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
      return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [XLEN-1:0] negate_w(input logic [XLEN-1:0] x, input logic en);
      return en ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [2*XLEN-1:0] negate_p(input logic [2*XLEN-1:0] x, input logic en);
      return en ? (~x + 1'b1) : x;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d;
   logic              ld_op, prep;

   logic [XLEN-1:0]   op1_q, op2_q, opnd_q;
   logic              is_div_q, sgn_q, neg_q, rneg_q, dbz_q;
   logic [2*XLEN-1:0] acc_q, step_acc, prod;
   logic [XLEN-1:0]   mag1, mag2, res_hi, res_lo;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .is_div_i (is_div_q),
      .acc_o    (step_acc)
   );

   assign mag1 = magnitude(op1_q, sgn_q);
   assign mag2 = magnitude(op2_q, sgn_q);
   assign prod = negate_p(acc_q, neg_q);

   // Divide by zero bypasses the sign fix-up entirely.
   always_comb begin
      if (!is_div_q) begin
         res_hi = prod[2*XLEN-1:XLEN];
         res_lo = prod[XLEN-1:0];
      end else if (dbz_q) begin
         res_hi = op1_q;
         res_lo = '1;
      end else begin
         res_hi = negate_w(acc_q[2*XLEN-1:XLEN], rneg_q);
         res_lo = negate_w(acc_q[XLEN-1:0], neg_q);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      ld_op   = 1'b0;
      prep    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               case (bus.func)
                  FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                     ld_op   = 1'b1;
                     state_d = S_PREP;
                  end
                  FUNC_MTHI: hi_d = bus.op1;
                  FUNC_MTLO: lo_d = bus.op1;
                  default: ;
               endcase
            end
         end
         S_PREP: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RUN;
               cnt_d   = '0;
               prep    = 1'b1;
            end
         end
         S_RUN: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!bus.flush) begin
               hi_d   = res_hi;
               lo_d   = res_lo;
               done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Operand and accumulator datapath; only meaningful while busy, so no reset.
   always_ff @(posedge clk) begin
      if (ld_op) begin
         op1_q    <= bus.op1;
         op2_q    <= bus.op2;
         is_div_q <= bus.func[1];
         sgn_q    <= ~bus.func[0];
      end
      if (prep) begin
         opnd_q <= is_div_q ? mag2 : mag1;
         acc_q  <= {{XLEN{1'b0}}, (is_div_q ? mag1 : mag2)};
         neg_q  <= sgn_q & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
         rneg_q <= sgn_q & op1_q[XLEN-1];
         dbz_q  <= (op2_q == '0);
      end else if (state_q == S_RUN) begin
         acc_q <= step_acc;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
